// File: rtl/adc_stim_source.sv
// rtl/adc_stim_source.sv - round-robin multi-channel ADC sample source with output FIFO
// Ramp/hold/LFSR per channel, one sample per PERIOD enabled clocks, drops counted when full.
module adc_stim_source #(
    parameter int                DWIDTH = 32,
    parameter int                NCHAN  = 4,
    parameter int                DEPTH  = 8,
    parameter int                PERIOD = 2,
    parameter int                STEP   = 1,
    parameter logic [DWIDTH-1:0] POLY   = DWIDTH'(32'h80200003),
    localparam int               CW     = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic [1:0]        mode,
    input  logic              load,
    input  logic [DWIDTH-1:0] start_value,
    output logic [DWIDTH-1:0] adcdata,
    output logic [CW-1:0]     adcchan,
    output logic              adc_valid,
    input  logic              input_ready,
    output logic              overflow,
    output logic [15:0]       drop_count
);
    localparam int TW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int AW = $clog2(DEPTH);
    localparam int NW = AW + 1;

    logic [TW-1:0]     cnt_q, cnt_d;
    logic [CW-1:0]     ptr_q, ptr_d;
    logic [DWIDTH-1:0] chreg_q [NCHAN];
    logic [DWIDTH-1:0] chreg_d [NCHAN];
    logic [DWIDTH-1:0] mem_data_q [DEPTH];
    logic [DWIDTH-1:0] mem_data_d [DEPTH];
    logic [CW-1:0]     mem_chan_q [DEPTH];
    logic [CW-1:0]     mem_chan_d [DEPTH];
    logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d;
    logic [NW-1:0]     count_q, count_d;
    logic              ovf_q, ovf_d;
    logic [15:0]       drops_q, drops_d;

    logic              tick, pop, push, drop, full;
    logic [DWIDTH-1:0] cur, lv, lnext, adv;

    always_comb begin
        tick  = enable && (cnt_q == TW'(PERIOD - 1));
        pop   = (count_q != '0) && input_ready;
        full  = (count_q == NW'(DEPTH));
        push  = tick && (!full || pop);
        drop  = tick && full && !pop;
        cur   = chreg_q[ptr_q];
        // All-zero state would lock the LFSR, so it is treated as a seed of 1.
        lv    = (cur == '0) ? DWIDTH'(1) : cur;
        lnext = lv[0] ? ((lv >> 1) ^ POLY) : (lv >> 1);
        case (mode)
            2'd0:    adv = cur + DWIDTH'(STEP);
            2'd2:    adv = lnext;
            default: adv = cur;
        endcase

        cnt_d      = cnt_q;
        ptr_d      = ptr_q;
        chreg_d    = chreg_q;
        mem_data_d = mem_data_q;
        mem_chan_d = mem_chan_q;
        wr_d       = wr_q;
        rd_d       = rd_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        drops_d    = drops_q;

        if (load) begin
            cnt_d   = '0;
            ptr_d   = '0;
            for (int c = 0; c < NCHAN; c++) chreg_d[c] = start_value + DWIDTH'(c);
            wr_d    = '0;
            rd_d    = '0;
            count_d = '0;
            ovf_d   = 1'b0;
            drops_d = '0;
        end else begin
            if (enable) cnt_d = tick ? '0 : cnt_q + TW'(1);
            if (tick) begin
                chreg_d[ptr_q] = adv;
                ptr_d = (ptr_q == CW'(NCHAN - 1)) ? '0 : ptr_q + CW'(1);
            end
            if (push) begin
                mem_data_d[wr_q] = cur;
                mem_chan_d[wr_q] = ptr_q;
                wr_d = wr_q + AW'(1);
            end
            if (pop) rd_d = rd_q + AW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + NW'(1);
                2'b01:   count_d = count_q - NW'(1);
                default: count_d = count_q;
            endcase
            if (drop) begin
                ovf_d = 1'b1;
                if (drops_q != 16'hFFFF) drops_d = drops_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            ptr_q   <= '0;
            for (int c = 0; c < NCHAN; c++) chreg_q[c] <= DWIDTH'(c);
            for (int i = 0; i < DEPTH; i++) begin
                mem_data_q[i] <= '0;
                mem_chan_q[i] <= '0;
            end
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            drops_q <= '0;
        end else begin
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            chreg_q    <= chreg_d;
            mem_data_q <= mem_data_d;
            mem_chan_q <= mem_chan_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            drops_q    <= drops_d;
        end
    end

    assign adcdata    = mem_data_q[rd_q];
    assign adcchan    = mem_chan_q[rd_q];
    assign adc_valid  = (count_q != '0);
    assign overflow   = ovf_q;
    assign drop_count = drops_q;
endmodule

// File: tb/tb_adc_stim_source.sv
// tb/tb_adc_stim_source.sv - self-checking bench for adc_stim_source
// Queue-based reference model plus per-scenario expected pop tables.
module tb_adc_stim_source;
    localparam int NCHAN  = 4;
    localparam int DEPTH  = 8;
    localparam int PERIOD = 2;
    localparam logic [31:0] POLY = 32'h80200003;
    localparam int NPOP = 9;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic        load = 1'b0;
    logic [31:0] start_value = '0;
    logic [31:0] adcdata;
    logic [1:0]  adcchan;
    logic        adc_valid;
    logic        input_ready = 1'b0;
    logic        overflow;
    logic [15:0] drop_count;

    adc_stim_source dut (
        .clock(clock), .reset(reset), .enable(enable), .mode(mode), .load(load),
        .start_value(start_value), .adcdata(adcdata), .adcchan(adcchan),
        .adc_valid(adc_valid), .input_ready(input_ready), .overflow(overflow),
        .drop_count(drop_count)
    );

    always #5 clock = ~clock;

    typedef struct { int chan; logic [31:0] data; } sample_t;
    typedef struct { logic [1:0] md; logic [31:0] sv; logic [31:0] exp_data [NPOP]; } row_t;

    int n_cmp = 0;
    int n_bad = 0;

    sample_t     q[$];
    sample_t     popq[$];
    int          m_phase, m_ptr, m_drops;
    logic [31:0] m_ch [NCHAN];
    bit          m_ovf;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] next_val(input logic [1:0] md, input logic [31:0] x);
        logic [31:0] v;
        if (md == 2'd0) return x + 32'd1;
        if (md != 2'd2) return x;
        v = (x == 0) ? 32'd1 : x;
        return v[0] ? ((v >> 1) ^ POLY) : (v >> 1);
    endfunction

    function automatic void model_reset();
        q.delete();
        m_phase = 0; m_ptr = 0; m_drops = 0; m_ovf = 0;
        for (int c = 0; c < NCHAN; c++) m_ch[c] = 32'(c);
    endfunction

    function automatic void model_step(input bit en, input logic [1:0] md, input bit ld,
                                       input logic [31:0] sv, input bit rdy);
        bit tick;
        if (ld) begin
            q.delete();
            m_phase = 0; m_ptr = 0; m_drops = 0; m_ovf = 0;
            for (int c = 0; c < NCHAN; c++) m_ch[c] = sv + 32'(c);
            return;
        end
        tick = 0;
        if (en) begin
            m_phase++;
            if (m_phase == PERIOD) begin m_phase = 0; tick = 1; end
        end
        if (rdy && q.size() > 0) void'(q.pop_front());
        if (tick) begin
            if (q.size() < DEPTH) q.push_back('{m_ptr, m_ch[m_ptr]});
            else begin
                m_ovf = 1;
                if (m_drops < 65535) m_drops++;
            end
            m_ch[m_ptr] = next_val(md, m_ch[m_ptr]);
            m_ptr = (m_ptr + 1) % NCHAN;
        end
    endfunction

    task automatic check_outputs();
        check("valid", 64'(adc_valid), 64'(q.size() != 0));
        if (q.size() != 0) begin
            check("data", 64'(adcdata), 64'(q[0].data));
            check("chan", 64'(adcchan), 64'(q[0].chan));
        end
        check("overflow", 64'(overflow), 64'(m_ovf));
        check("drop_count", 64'(drop_count), 64'(m_drops));
    endtask

    task automatic cycle(input bit en, input logic [1:0] md, input bit ld,
                         input logic [31:0] sv, input bit rdy);
        enable = en; mode = md; load = ld; start_value = sv; input_ready = rdy;
        #1;
        if (adc_valid && rdy) popq.push_back('{int'(adcchan), adcdata});
        @(posedge clock);
        model_step(en, md, ld, sv, rdy);
        @(negedge clock);
        check_outputs();
    endtask

    task automatic collect(input int n, input logic [1:0] md, input bit en);
        int k = 0;
        while (popq.size() < n && k < 100) begin
            cycle(en, md, 1'b0, 32'd0, 1'b1);
            k++;
        end
        check("pop_budget", 64'(popq.size() >= n), 64'd1);
    endtask

    row_t rows [6];

    initial begin
        int first_valid;
        rows[0] = '{2'd0, 32'd1, '{1, 2, 3, 4, 2, 3, 4, 5, 3}};
        rows[1] = '{2'd0, 32'hFFFFFFFE, '{32'hFFFFFFFE, 32'hFFFFFFFF, 0, 1, 32'hFFFFFFFF, 0, 1, 2, 0}};
        rows[2] = '{2'd2, 32'd1, '{1, 2, 3, 4, 32'h80200003, 1, 32'h80200002, 2, 32'hC0300002}};
        rows[3] = '{2'd2, 32'd0, '{0, 1, 2, 3, 32'h80200003, 32'h80200003, 1, 32'h80200002, 32'hC0300002}};
        rows[4] = '{2'd1, 32'd5, '{5, 6, 7, 8, 5, 6, 7, 8, 5}};
        rows[5] = '{2'd3, 32'd10, '{10, 11, 12, 13, 10, 11, 12, 13, 10}};

        model_reset();
        repeat (2) @(negedge clock);
        check("rst_valid", 64'(adc_valid), 64'd0);
        check("rst_data", 64'(adcdata), 64'd0);
        check("rst_chan", 64'(adcchan), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        check("rst_drops", 64'(drop_count), 64'd0);
        reset = 1'b1;

        foreach (rows[r]) begin
            cycle(1'b0, rows[r].md, 1'b1, rows[r].sv, 1'b1);
            popq.delete();
            first_valid = -1;
            for (int k = 1; k <= 60 && popq.size() < NPOP; k++) begin
                cycle(1'b1, rows[r].md, 1'b0, 32'd0, 1'b1);
                if (first_valid < 0 && adc_valid) first_valid = k;
            end
            check("first_valid", 64'(first_valid), 64'(PERIOD));
            check("row_pops", 64'(popq.size() >= NPOP), 64'd1);
            for (int i = 0; i < NPOP && i < popq.size(); i++) begin
                check($sformatf("row%0d_chan%0d", r, i), 64'(popq[i].chan), 64'(i % NCHAN));
                check($sformatf("row%0d_data%0d", r, i), 64'(popq[i].data), 64'(rows[r].exp_data[i]));
            end
        end

        // Overflow: 20 stalled clocks give 10 ticks, 8 kept and 2 dropped.
        cycle(1'b0, 2'd0, 1'b1, 32'd1, 1'b0);
        repeat (20) cycle(1'b1, 2'd0, 1'b0, 32'd0, 1'b0);
        check("ovf_drops", 64'(drop_count), 64'd2);
        check("ovf_flag", 64'(overflow), 64'd1);
        popq.delete();
        collect(8, 2'd0, 1'b1);
        for (int i = 0; i < 8 && i < popq.size(); i++) begin
            check($sformatf("drain_chan%0d", i), 64'(popq[i].chan), 64'(i % NCHAN));
            check($sformatf("drain_data%0d", i), 64'(popq[i].data), 64'(1 + i / NCHAN + i % NCHAN));
        end
        check("ovf_sticky", 64'(overflow), 64'd1);

        // Asynchronous reset with a full FIFO, between clock edges.
        repeat (20) cycle(1'b1, 2'd0, 1'b0, 32'd0, 1'b0);
        #2 reset = 1'b0;
        #1;
        check("async_valid", 64'(adc_valid), 64'd0);
        check("async_drops", 64'(drop_count), 64'd0);
        check("async_ovf", 64'(overflow), 64'd0);
        model_reset();
        @(negedge clock);
        reset = 1'b1;
        popq.delete();
        collect(2, 2'd0, 1'b1);
        if (popq.size() >= 2) begin
            check("post_rst_chan0", 64'(popq[0].chan), 64'd0);
            check("post_rst_data0", 64'(popq[0].data), 64'd0);
            check("post_rst_chan1", 64'(popq[1].chan), 64'd1);
        end

        // Pause generation with 3 buffered; they drain, then ptr resumes at ch3.
        cycle(1'b0, 2'd0, 1'b1, 32'd1, 1'b0);
        repeat (6) cycle(1'b1, 2'd0, 1'b0, 32'd0, 1'b0);
        popq.delete();
        repeat (10) cycle(1'b0, 2'd0, 1'b0, 32'd0, 1'b1);
        check("pause_pops", 64'(popq.size()), 64'd3);
        check("pause_idle", 64'(adc_valid), 64'd0);
        first_valid = -1;
        for (int k = 1; k <= 10 && first_valid < 0; k++) begin
            cycle(1'b1, 2'd0, 1'b0, 32'd0, 1'b0);
            if (adc_valid) first_valid = k;
        end
        check("resume_latency", 64'(first_valid), 64'(PERIOD));
        check("resume_chan", 64'(adcchan), 64'd3);
        check("resume_data", 64'(adcdata), 64'd4);

        // Randomised traffic against the reference model.
        for (int i = 0; i < 600; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 59) == 0), $urandom, 1'($urandom_range(0, 2) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
